// File: rtl/hms_counter.sv
// Time-of-day counter: prescaled seconds/minutes/hours with up/down counting,
// clamped preset load and registered carry/wrap pulses.
module hms_counter #(
    parameter int TICK_DIV = 1,
    parameter int SEC_MOD  = 60,
    parameter int MIN_MOD  = 60,
    parameter int HR_MOD   = 24,
    parameter int SEC_W    = 6,
    parameter int MIN_W    = 6,
    parameter int HR_W     = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             dir,
    input  logic             load,
    input  logic [SEC_W-1:0] ld_sec,
    input  logic [MIN_W-1:0] ld_min,
    input  logic [HR_W-1:0]  ld_hr,
    output logic [SEC_W-1:0] second,
    output logic [MIN_W-1:0] minute,
    output logic [HR_W-1:0]  hour,
    output logic             sec_tick,
    output logic             min_carry,
    output logic             hr_carry,
    output logic             day_wrap,
    output logic             ld_err
);

    localparam int DIV_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(TICK_DIV - 1);
    localparam logic [SEC_W-1:0] SEC_LAST = SEC_W'(SEC_MOD - 1);
    localparam logic [MIN_W-1:0] MIN_LAST = MIN_W'(MIN_MOD - 1);
    localparam logic [HR_W-1:0]  HR_LAST  = HR_W'(HR_MOD - 1);

    logic [DIV_W-1:0] div_cnt;
    logic             tick;

    logic             sec_wrap, min_wrap, hr_wrap;
    logic [SEC_W-1:0] sec_step;
    logic [MIN_W-1:0] min_step;
    logic [HR_W-1:0]  hr_step;

    logic             sec_bad, min_bad, hr_bad;
    logic [SEC_W-1:0] sec_ld;
    logic [MIN_W-1:0] min_ld;
    logic [HR_W-1:0]  hr_ld;

    assign tick = en && (div_cnt == DIV_LAST);

    // A field "wraps" when it is at the boundary for the current direction;
    // that wrap is the carry/borrow into the next field up.
    always_comb begin
        sec_wrap = dir ? (second == '0) : (second == SEC_LAST);
        min_wrap = dir ? (minute == '0) : (minute == MIN_LAST);
        hr_wrap  = dir ? (hour   == '0) : (hour   == HR_LAST);

        if (sec_wrap)
            sec_step = dir ? SEC_LAST : '0;
        else
            sec_step = dir ? (second - SEC_W'(1)) : (second + SEC_W'(1));

        if (min_wrap)
            min_step = dir ? MIN_LAST : '0;
        else
            min_step = dir ? (minute - MIN_W'(1)) : (minute + MIN_W'(1));

        if (hr_wrap)
            hr_step = dir ? HR_LAST : '0;
        else
            hr_step = dir ? (hour - HR_W'(1)) : (hour + HR_W'(1));
    end

    // Extra bit on the compare so a modulus of exactly 2^W is representable.
    always_comb begin
        sec_bad = {1'b0, ld_sec} >= (SEC_W + 1)'(SEC_MOD);
        min_bad = {1'b0, ld_min} >= (MIN_W + 1)'(MIN_MOD);
        hr_bad  = {1'b0, ld_hr}  >= (HR_W + 1)'(HR_MOD);
        sec_ld  = sec_bad ? SEC_LAST : ld_sec;
        min_ld  = min_bad ? MIN_LAST : ld_min;
        hr_ld   = hr_bad  ? HR_LAST  : ld_hr;
    end

    // NOTE: state uses non-blocking assignments so every register samples
    // pre-edge values; blocking here would let the cascade see updated fields.
    always_ff @(posedge clk) begin
        if (rst) begin
            div_cnt   <= '0;
            second    <= '0;
            minute    <= '0;
            hour      <= '0;
            sec_tick  <= 1'b0;
            min_carry <= 1'b0;
            hr_carry  <= 1'b0;
            day_wrap  <= 1'b0;
            ld_err    <= 1'b0;
        end else if (load) begin
            div_cnt   <= '0;
            second    <= sec_ld;
            minute    <= min_ld;
            hour      <= hr_ld;
            sec_tick  <= 1'b0;
            min_carry <= 1'b0;
            hr_carry  <= 1'b0;
            day_wrap  <= 1'b0;
            ld_err    <= sec_bad || min_bad || hr_bad;
        end else begin
            sec_tick  <= tick;
            min_carry <= tick && sec_wrap;
            hr_carry  <= tick && sec_wrap && min_wrap;
            day_wrap  <= tick && sec_wrap && min_wrap && hr_wrap;
            ld_err    <= 1'b0;

            if (en)
                div_cnt <= tick ? '0 : (div_cnt + DIV_W'(1));

            if (tick) begin
                second <= sec_step;
                if (sec_wrap) begin
                    minute <= min_step;
                    if (min_wrap)
                        hour <= hr_step;
                end
            end
        end
    end

endmodule
